// File: rtl/pmod_cls_line_writer.sv
// Command sequencer for the Pmod CLS SPI driver: clear, cursor row 0, line 1, cursor row 1, line 2.
// Optional PMOD_CLS_SKIP_UNCHANGED_EN: skip the whole update when both lines match the last written pair.
module pmod_cls_line_writer #(
    parameter int unsigned PARAM_CLEAR_ON_UPDATE = 1
) (
    input  logic         i_clk_20mhz,
    input  logic         i_rstn_20mhz,
    input  logic [127:0] i_dat_ascii_line1,
    input  logic [127:0] i_dat_ascii_line2,
    input  logic         i_update_req,
    input  logic         i_tx_ready,
    input  logic         i_spi_idle,
    output logic         o_ready,
    output logic         o_done,
    output logic [7:0]   o_tx_data,
    output logic         o_tx_enqueue,
    output logic         o_go_stand,
    output logic [10:0]  o_tx_len,
    output logic [10:0]  o_rx_len,
    output logic [1:0]   o_wait_cyc
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PUSH, S_GO, S_WAIT_ACK, S_WAIT_IDLE, S_NEXT, S_DONE
    } state_t;

    typedef enum logic [2:0] {
        STEP_CLR, STEP_CUR1, STEP_DAT1, STEP_CUR2, STEP_DAT2
    } step_t;

    state_t       state_q, state_d;
    step_t        step_q;
    logic [4:0]   idx_q;
    logic [10:0]  tx_len_q;
    logic [127:0] line1_q, line2_q;
    logic [4:0]   step_len;
    logic [7:0]   cur_byte;
    logic [3:0]   ci;
    logic         accept;
    logic         last_byte;
    logic         skip;
    step_t        start_step;

    assign accept     = (state_q == S_IDLE) && i_update_req && i_spi_idle;
    assign start_step = (PARAM_CLEAR_ON_UPDATE != 0) ? STEP_CLR : STEP_CUR1;
    assign ci         = idx_q[3:0];
    assign last_byte  = (idx_q == (step_len - 5'd1));

`ifdef PMOD_CLS_SKIP_UNCHANGED_EN
    logic [127:0] last1_q, last2_q;
    logic         last_vld_q;

    assign skip = last_vld_q && (i_dat_ascii_line1 == last1_q) && (i_dat_ascii_line2 == last2_q);

    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            last1_q    <= '0;
            last2_q    <= '0;
            last_vld_q <= 1'b0;
        end else if (state_q == S_DONE) begin
            last1_q    <= line1_q;
            last2_q    <= line2_q;
            last_vld_q <= 1'b1;
        end
    end
`else
    assign skip = 1'b0;
`endif

    always_comb begin
        step_len = 5'd16;
        case (step_q)
            STEP_CLR:             step_len = 5'd3;
            STEP_CUR1, STEP_CUR2: step_len = 5'd6;
            default:              step_len = 5'd16;
        endcase
    end

    // Character 0 sits in the top byte, so byte i lives at bit offset 8*(15-i).
    always_comb begin
        cur_byte = 8'h00;
        case (step_q)
            STEP_CLR: begin
                case (idx_q)
                    5'd0:    cur_byte = 8'h1B;
                    5'd1:    cur_byte = 8'h5B;
                    default: cur_byte = 8'h6A;
                endcase
            end
            STEP_CUR1, STEP_CUR2: begin
                case (idx_q)
                    5'd0:    cur_byte = 8'h1B;
                    5'd1:    cur_byte = 8'h5B;
                    5'd2:    cur_byte = (step_q == STEP_CUR1) ? 8'h30 : 8'h31;
                    5'd3:    cur_byte = 8'h3B;
                    5'd4:    cur_byte = 8'h30;
                    default: cur_byte = 8'h48;
                endcase
            end
            STEP_DAT1: cur_byte = line1_q[{~ci, 3'b000} +: 8];
            STEP_DAT2: cur_byte = line2_q[{~ci, 3'b000} +: 8];
            default:   cur_byte = 8'h00;
        endcase
    end

    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) state_q <= S_IDLE;
        else               state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (accept) state_d = skip ? S_DONE : S_LOAD;
            S_LOAD:      state_d = S_PUSH;
            S_PUSH:      if (i_tx_ready && last_byte) state_d = S_GO;
            S_GO:        state_d = S_WAIT_ACK;
            S_WAIT_ACK:  if (!i_spi_idle) state_d = S_WAIT_IDLE;
            S_WAIT_IDLE: if (i_spi_idle) state_d = S_NEXT;
            S_NEXT:      state_d = (step_q == STEP_DAT2) ? S_DONE : S_LOAD;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            step_q   <= STEP_CLR;
            idx_q    <= '0;
            tx_len_q <= '0;
            line1_q  <= '0;
            line2_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        line1_q <= i_dat_ascii_line1;
                        line2_q <= i_dat_ascii_line2;
                        step_q  <= start_step;
                    end
                end
                S_LOAD: begin
                    tx_len_q <= {6'd0, step_len};
                    idx_q    <= '0;
                end
                S_PUSH: if (i_tx_ready) idx_q <= idx_q + 5'd1;
                S_NEXT: begin
                    case (step_q)
                        STEP_CLR:  step_q <= STEP_CUR1;
                        STEP_CUR1: step_q <= STEP_DAT1;
                        STEP_DAT1: step_q <= STEP_CUR2;
                        STEP_CUR2: step_q <= STEP_DAT2;
                        default:   step_q <= STEP_DAT2;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign o_ready      = (state_q == S_IDLE);
    assign o_done       = (state_q == S_DONE);
    assign o_go_stand   = (state_q == S_GO);
    assign o_tx_enqueue = (state_q == S_PUSH) && i_tx_ready;
    assign o_tx_data    = (state_q == S_PUSH) ? cur_byte : '0;
    assign o_tx_len     = tx_len_q;
    assign o_rx_len     = '0;
    assign o_wait_cyc   = '0;

endmodule

// File: tb/tb_pmod_cls_line_writer.sv
// Directed bench for pmod_cls_line_writer with a simple busy/idle SPI driver model.
module tb_pmod_cls_line_writer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] line1 = '0;
    logic [127:0] line2 = '0;
    logic         update_req = 1'b0;
    logic         tx_base = 1'b1;
    logic         tx_rand = 1'b0;
    logic         rnd_rdy = 1'b1;
    logic         spi_hold = 1'b0;
    logic [2:0]   spi_cnt = '0;
    logic         tx_ready, spi_idle;
    logic         ready, done, tx_enqueue, go_stand;
    logic [7:0]   tx_data;
    logic [10:0]  tx_len, rx_len;
    logic [1:0]   wait_cyc;

    int           cyc = 0;
    int           done_cnt = 0;
    logic [7:0]   got_bytes[$];
    int           enq_cyc[$];
    int           go_lens[$];
    int           go_at[$];
    logic [7:0]   exp_bytes[$];
    int           n_checks = 0;
    int           n_pass = 0;

    localparam logic [127:0] L1_A = "HELLO WORLD     ";
    localparam logic [127:0] L2_A = "ACL2 X=+0000    ";
    localparam logic [127:0] L2_B = "ACL2 X=-0042    ";

    always #25 clk = ~clk;

    assign tx_ready = tx_rand ? rnd_rdy : tx_base;
    assign spi_idle = (spi_cnt == 3'd0) && !spi_hold;

    pmod_cls_line_writer #(.PARAM_CLEAR_ON_UPDATE(1)) dut (
        .i_clk_20mhz      (clk),
        .i_rstn_20mhz     (rst_n),
        .i_dat_ascii_line1(line1),
        .i_dat_ascii_line2(line2),
        .i_update_req     (update_req),
        .i_tx_ready       (tx_ready),
        .i_spi_idle       (spi_idle),
        .o_ready          (ready),
        .o_done           (done),
        .o_tx_data        (tx_data),
        .o_tx_enqueue     (tx_enqueue),
        .o_go_stand       (go_stand),
        .o_tx_len         (tx_len),
        .o_rx_len         (rx_len),
        .o_wait_cyc       (wait_cyc)
    );

    // SPI driver model: busy for four cycles after each go strobe.
    always @(posedge clk) begin
        if (go_stand)              spi_cnt <= 3'd4;
        else if (spi_cnt != 3'd0)  spi_cnt <= spi_cnt - 3'd1;
    end

    always @(negedge clk) rnd_rdy <= 1'($urandom_range(0, 1));

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_enqueue) begin
            got_bytes.push_back(tx_data);
            enq_cyc.push_back(cyc);
        end
        if (go_stand) begin
            go_lens.push_back(int'(tx_len));
            go_at.push_back(got_bytes.size());
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"},   32'(ready), 32'd1);
        chk({tag, "_done"},    32'(done), 32'd0);
        chk({tag, "_enqueue"}, 32'(tx_enqueue), 32'd0);
        chk({tag, "_go"},      32'(go_stand), 32'd0);
        chk({tag, "_tx_len"},  32'(tx_len), 32'd0);
        chk({tag, "_rx_len"},  32'(rx_len), 32'd0);
        chk({tag, "_wait"},    32'(wait_cyc), 32'd0);
    endtask

    // Pulse a request across one rising edge; returns the cycle index of that edge.
    task automatic pulse_req(output int acc);
        @(negedge clk);
        update_req = 1'b1;
        @(posedge clk);
        acc = cyc;
        @(negedge clk);
        update_req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int start, input int budget);
        int n;
        n = 0;
        while (done_cnt == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt - start), 32'd1);
    endtask

    task automatic wait_bytes(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (got_bytes.size() < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_bytes_reached"}, 32'(got_bytes.size() >= target), 32'd1);
    endtask

    task automatic build_exp(input logic [127:0] l1, input logic [127:0] l2);
        exp_bytes = '{8'h1B, 8'h5B, 8'h6A, 8'h1B, 8'h5B, 8'h30, 8'h3B, 8'h30, 8'h48};
        for (int i = 0; i < 16; i++) exp_bytes.push_back(l1[127 - 8*i -: 8]);
        exp_bytes.push_back(8'h1B); exp_bytes.push_back(8'h5B); exp_bytes.push_back(8'h31);
        exp_bytes.push_back(8'h3B); exp_bytes.push_back(8'h30); exp_bytes.push_back(8'h48);
        for (int i = 0; i < 16; i++) exp_bytes.push_back(l2[127 - 8*i -: 8]);
    endtask

    task automatic check_update(input string tag, input int b0, input int g0);
        int exp_len[5] = '{3, 6, 16, 6, 16};
        int exp_at[5]  = '{3, 9, 25, 31, 47};
        chk({tag, "_nbytes"}, 32'(got_bytes.size() - b0), 32'd47);
        chk({tag, "_ngo"},    32'(go_lens.size() - g0), 32'd5);
        for (int i = 0; i < 47; i++)
            if (b0 + i < got_bytes.size())
                chk($sformatf("%s_byte%0d", tag, i), 32'(got_bytes[b0 + i]), 32'(exp_bytes[i]));
        for (int k = 0; k < 5; k++)
            if (g0 + k < go_lens.size()) begin
                chk($sformatf("%s_go%0d_len", tag, k), 32'(go_lens[g0 + k]), 32'(exp_len[k]));
                chk($sformatf("%s_go%0d_after", tag, k), 32'(go_at[g0 + k] - b0), 32'(exp_at[k]));
            end
    endtask

    initial begin
        int acc, b0, g0, d0;

        // Reset state
        repeat (3) @(negedge clk);
        check_idle_outputs("rst_held");
        chk("rst_data", 32'(tx_data), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("rst_released");

        // Request while SPI busy is dropped
        spi_hold = 1'b1;
        b0 = got_bytes.size();
        pulse_req(acc);
        chk("drop_ready", 32'(ready), 32'd1);
        repeat (4) @(negedge clk);
        spi_hold = 1'b0;
        repeat (4) @(negedge clk);
        chk("drop_ready_later", 32'(ready), 32'd1);
        chk("drop_no_bytes", 32'(got_bytes.size() - b0), 32'd0);

        // Full update, no backpressure
        line1 = L1_A; line2 = L2_A;
        build_exp(L1_A, L2_A);
        b0 = got_bytes.size(); g0 = go_lens.size(); d0 = done_cnt;
        pulse_req(acc);
        chk("busy_after_accept", 32'(ready), 32'd0);
        wait_done("upd1", d0, 600);
        check_update("upd1", b0, g0);
        if (b0 < enq_cyc.size()) chk("upd1_latency", 32'(enq_cyc[b0] - acc), 32'd2);
        repeat (5) @(negedge clk);
        chk("upd1_single_done", 32'(done_cnt - d0), 32'd1);
        chk("upd1_ready", 32'(ready), 32'd1);

        // Random backpressure, plus an ignored request during DAT2
        line2 = L2_B;
        build_exp(L1_A, L2_B);
        b0 = got_bytes.size(); g0 = go_lens.size(); d0 = done_cnt;
        tx_rand = 1'b1;
        pulse_req(acc);
        wait_bytes("upd2_dat2", b0 + 33, 800);
        pulse_req(acc);
        wait_done("upd2", d0, 800);
        tx_rand = 1'b0;
        repeat (20) @(negedge clk);
        check_update("upd2", b0, g0);
        chk("upd2_single_done", 32'(done_cnt - d0), 32'd1);
        chk("upd2_ready", 32'(ready), 32'd1);

        // Reset pulse mid-DAT1 aborts the sequence
        line2 = L2_A;
        b0 = got_bytes.size(); d0 = done_cnt;
        pulse_req(acc);
        wait_bytes("mid_dat1", b0 + 14, 400);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        b0 = got_bytes.size(); g0 = go_lens.size();
        repeat (40) @(negedge clk);
        chk("mid_rst_no_bytes", 32'(got_bytes.size() - b0), 32'd0);
        chk("mid_rst_no_go",    32'(go_lens.size() - g0), 32'd0);
        chk("mid_rst_no_done",  32'(done_cnt - d0), 32'd0);
        chk("mid_rst_ready",    32'(ready), 32'd1);

`ifdef PMOD_CLS_SKIP_UNCHANGED_EN
        // First write after reset is full, identical repeat is skipped, changed line2 is full
        build_exp(L1_A, L2_A);
        b0 = got_bytes.size(); g0 = go_lens.size(); d0 = done_cnt;
        pulse_req(acc);
        wait_done("skip_first", d0, 600);
        check_update("skip_first", b0, g0);
        repeat (3) @(negedge clk);
        b0 = got_bytes.size(); g0 = go_lens.size(); d0 = done_cnt;
        pulse_req(acc);
        chk("skip_done_pulse", 32'(done), 32'd1);
        @(negedge clk);
        chk("skip_done_gone", 32'(done), 32'd0);
        chk("skip_ready", 32'(ready), 32'd1);
        repeat (10) @(negedge clk);
        chk("skip_no_bytes", 32'(got_bytes.size() - b0), 32'd0);
        chk("skip_no_go", 32'(go_lens.size() - g0), 32'd0);
        chk("skip_one_done", 32'(done_cnt - d0), 32'd1);
        line2 = L2_B;
        build_exp(L1_A, L2_B);
        b0 = got_bytes.size(); g0 = go_lens.size(); d0 = done_cnt;
        pulse_req(acc);
        wait_done("skip_changed", d0, 600);
        check_update("skip_changed", b0, g0);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
